// File: rtl/turn_sequencer.sv
// Turn controller for the 2048 board: move -> commit -> spawn -> win/lose check.
// Optional feature: define SPAWN_FOUR_EN to let rand_in[4] select a spawned 4 instead of 2.
module turn_sequencer #(
    parameter int TILE_W       = 12,
    parameter int WIN_VALUE    = 2048,
    parameter int MOVE_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             btn_dir,
    input  logic [4:0]             rand_in,
    input  logic [15:0][TILE_W-1:0] board_in,
    input  logic                   move_ready,
    input  logic [15:0][TILE_W-1:0] moved_board,
    output logic                   move_en,
    output logic [3:0]             move_dir,
    output logic                   board_we,
    output logic                   spawn_we,
    output logic [3:0]             spawn_idx,
    output logic [TILE_W-1:0]      spawn_val,
    output logic                   busy,
    output logic                   win,
    output logic                   lose,
    output logic                   move_err
);

    localparam int CNT_W = $clog2(MOVE_TIMEOUT + 1);
    localparam logic [TILE_W-1:0] WIN_TILE = TILE_W'(WIN_VALUE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MOVE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_COMPARE,
        S_SPAWN,
        S_CHECK,
        S_OVER
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  move_cnt;
    logic [3:0]        scan_ptr;
    logic [3:0]        scan_cnt;
    logic              armed;
    logic              dir_one_hot;
    logic              accept;
    logic              has_win;
    logic              has_zero;
    logic              has_pair;
    logic [TILE_W-1:0] spawn_tile;

`ifdef SPAWN_FOUR_EN
    assign spawn_tile = rand_in[4] ? TILE_W'(4) : TILE_W'(2);
`else
    logic unused_rand_four;
    assign unused_rand_four = rand_in[4];
    assign spawn_tile       = TILE_W'(2);
`endif

    assign dir_one_hot = (btn_dir != 4'd0) && ((btn_dir & (btn_dir - 4'd1)) == 4'd0);
    assign accept      = (state == S_IDLE) && armed && dir_one_hot;
    assign move_en     = (state == S_MOVE);
    assign busy        = (state == S_MOVE) || (state == S_COMPARE) ||
                         (state == S_SPAWN) || (state == S_CHECK);

    // Board scan for the end-of-turn check: win tile, free cell, mergeable neighbours.
    always_comb begin
        has_win  = 1'b0;
        has_zero = 1'b0;
        has_pair = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (board_in[i] >= WIN_TILE) has_win = 1'b1;
            if (board_in[i] == '0)       has_zero = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (board_in[r*4+c] == board_in[r*4+c+1]) has_pair = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (board_in[i] == board_in[i+4]) has_pair = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        move_err   = 1'b0;
        board_we   = 1'b0;
        spawn_we   = 1'b0;
        spawn_idx  = 4'd0;
        spawn_val  = '0;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_MOVE;
            end
            S_MOVE: begin
                if (move_ready) begin
                    state_next = S_COMPARE;
                end else if (move_cnt == CNT_LAST) begin
                    move_err   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (moved_board == board_in) begin
                    state_next = S_IDLE;
                end else begin
                    board_we   = 1'b1;
                    state_next = S_SPAWN;
                end
            end
            S_SPAWN: begin
                // A full board after a real move is impossible, but give up after one lap.
                if (board_in[scan_ptr] == '0) begin
                    spawn_we   = 1'b1;
                    spawn_idx  = scan_ptr;
                    spawn_val  = spawn_tile;
                    state_next = S_CHECK;
                end else if (scan_cnt == 4'd15) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (has_win || (!has_zero && !has_pair)) state_next = S_OVER;
                else                                      state_next = S_IDLE;
            end
            S_OVER:  state_next = S_OVER;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            armed    <= 1'b1;
            move_dir <= 4'd0;
            move_cnt <= '0;
            scan_ptr <= 4'd0;
            scan_cnt <= 4'd0;
            win      <= 1'b0;
            lose     <= 1'b0;
        end else begin
            state <= state_next;

            // A held button yields one turn; re-arm only once it is released.
            if (btn_dir == 4'd0) armed <= 1'b1;
            else if (accept)     armed <= 1'b0;

            if (accept) move_dir <= btn_dir;

            if (state == S_MOVE) move_cnt <= move_cnt + 1'b1;
            else                 move_cnt <= '0;

            if (state == S_COMPARE) begin
                scan_ptr <= rand_in[3:0];
                scan_cnt <= 4'd0;
            end else if (state == S_SPAWN) begin
                scan_ptr <= scan_ptr + 4'd1;
                scan_cnt <= scan_cnt + 4'd1;
            end

            if (state == S_CHECK) begin
                if (has_win)                    win  <= 1'b1;
                else if (!has_zero && !has_pair) lose <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: directed turns push expected write/error
// events into a queue, a negedge monitor pops and compares them as the DUT emits them.
module tb_turn_sequencer;

    typedef logic [15:0][11:0] brd_t;
    typedef struct {
        int kind;
        int idx;
        int val;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn_dir = 4'd0;
    logic [4:0]  rand_in = 5'd0;
    brd_t        board_in = '0;
    logic        move_ready = 1'b0;
    brd_t        moved_board = '0;
    logic        move_en;
    logic [3:0]  move_dir;
    logic        board_we;
    logic        spawn_we;
    logic [3:0]  spawn_idx;
    logic [11:0] spawn_val;
    logic        busy;
    logic        win;
    logic        lose;
    logic        move_err;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   check_cnt = 0;
    int   cyc = 0;
    int   turns = 0;
    int   en_cyc = 0;
    int   we_cyc = 0;
    int   ready_delay = 1;
    int   wait_cnt = 0;
    logic prev_en = 1'b0;
    logic load_req = 1'b0;
    brd_t load_val = '0;

    turn_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .btn_dir     (btn_dir),
        .rand_in     (rand_in),
        .board_in    (board_in),
        .move_ready  (move_ready),
        .moved_board (moved_board),
        .move_en     (move_en),
        .move_dir    (move_dir),
        .board_we    (board_we),
        .spawn_we    (spawn_we),
        .spawn_idx   (spawn_idx),
        .spawn_val   (spawn_val),
        .busy        (busy),
        .win         (win),
        .lose        (lose),
        .move_err    (move_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External board register, written only through the DUT's strobes.
    always @(posedge clk) begin
        if (load_req) begin
            board_in <= load_val;
        end else begin
            if (board_we) board_in <= moved_board;
            if (spawn_we) board_in[spawn_idx] <= spawn_val;
        end
    end

    // Movement FSM stand-in: answers move_en after ready_delay cycles, never if negative.
    always @(negedge clk) begin
        if (move_en && !move_ready && ready_delay >= 0) begin
            if (wait_cnt >= ready_delay) move_ready = 1'b1;
            else wait_cnt++;
        end else begin
            move_ready = 1'b0;
            wait_cnt   = 0;
        end
    end

    task automatic check_output(input string name, input longint act, input longint exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write strobe or timeout pulse must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        int   kind;
        if (move_en && !prev_en) begin
            en_cyc = cyc;
            turns++;
        end
        prev_en = move_en;
        if (board_we || spawn_we || move_err) begin
            kind = board_we ? 0 : (spawn_we ? 1 : 2);
            if (board_we && spawn_we) check_output("we_exclusive", 1, 0);
            if (board_we) we_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_output("unexpected_event_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                check_output("event_kind", kind, e.kind);
                if (kind == 1 && e.kind == 1) begin
                    check_output("spawn_idx", spawn_idx, e.idx);
                    check_output("spawn_val", spawn_val, e.val);
                    check_output("spawn_latency", cyc - we_cyc, e.lat);
                end
                if (kind == 2 && e.kind == 2)
                    check_output("timeout_cycle", cyc - en_cyc + 1, e.lat);
            end
        end
    end

    task automatic push_exp(input int kind, input int idx, input int val, input int lat);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state();
        check_output("reset_outputs",
            {move_en, move_dir, board_we, spawn_we, spawn_idx, spawn_val, busy, win, lose, move_err}, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        btn_dir = 4'd0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
    endtask

    task automatic load_board(input brd_t b);
        @(negedge clk);
        load_val = b;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [3:0] dir);
        @(negedge clk);
        btn_dir = dir;
        @(negedge clk);
        btn_dir = 4'd0;
        check_output("move_en_after_accept", move_en, 1);
        check_output("move_dir_latched", move_dir, dir);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        @(negedge clk);
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output("turn_finished", busy, 0);
    endtask

    function automatic brd_t checker_board();
        brd_t b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b[r*4+c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd8;
        return b;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        brd_t b;
        brd_t m;
        int   t0;
        int   n;

        // 1) simple move with immediate spawn at cell 0
        apply_reset();
        b = '0; b[0] = 12'd2;
        load_board(b);
        m = '0; m[3] = 12'd2;
        moved_board = m;
        rand_in     = 5'd0;
        ready_delay = 2;
        push_exp(0, 0, 0, 0);
        push_exp(1, 0, 2, 1);
        apply_stimulus(4'b0001);
        wait_idle(40);
        check_output("t1_queue_drained", exp_q.size(), 0);
        b = '0; b[0] = 12'd2; b[3] = 12'd2;
        check_output("t1_board", (board_in == b), 1);

        // 2) illegal move: no writes at all
        moved_board = board_in;
        apply_stimulus(4'b0010);
        wait_idle(40);
        check_output("t2_queue_drained", exp_q.size(), 0);
        check_output("t2_board_unchanged", (board_in == b), 1);

        // 3) held button gives one turn; multi-hot ignored; release re-arms
        apply_reset();
        b = '0; b[0] = 12'd2;
        load_board(b);
        m = '0; m[1] = 12'd2;
        moved_board = m;
        ready_delay = 1;
        push_exp(0, 0, 0, 0);
        push_exp(1, 0, 2, 1);
        t0 = turns;
        @(negedge clk);
        btn_dir = 4'b0100;
        repeat (200) @(negedge clk);
        check_output("t3_held_one_turn", turns - t0, 1);
        check_output("t3_idle_while_held", busy, 0);
        btn_dir = 4'd0;
        @(negedge clk);
        btn_dir = 4'b0110;
        repeat (10) @(negedge clk);
        check_output("t3_multi_hot_ignored", turns - t0, 1);
        btn_dir = 4'd0;
        m = '0; m[0] = 12'd4;
        moved_board = m;
        push_exp(0, 0, 0, 0);
        push_exp(1, 1, 2, 2);
        apply_stimulus(4'b0100);
        wait_idle(40);
        check_output("t3_second_turn", turns - t0, 2);
        check_output("t3_queue_drained", exp_q.size(), 0);

        // 4) scan pointer wraps 15 -> 0 -> 1 -> 2
        apply_reset();
        b = '0; b[15] = 12'd4; b[0] = 12'd8; b[1] = 12'd16;
        load_board(b);
        m = b; m[5] = 12'd2;
        moved_board = m;
        rand_in     = 5'd15;
        push_exp(0, 0, 0, 0);
        push_exp(1, 2, 2, 4);
        apply_stimulus(4'b1000);
        wait_idle(40);
        check_output("t4_queue_drained", exp_q.size(), 0);
        rand_in = 5'd0;

        // 5a) 2048 reached: win sticky, buttons ignored
        apply_reset();
        b = '0; b[0] = 12'd1024; b[1] = 12'd1024;
        load_board(b);
        m = '0; m[0] = 12'd2048;
        moved_board = m;
        push_exp(0, 0, 0, 0);
        push_exp(1, 1, 2, 2);
        apply_stimulus(4'b0010);
        wait_idle(40);
        check_output("t5_win", win, 1);
        check_output("t5_no_lose", lose, 0);
        t0 = turns;
        @(negedge clk);
        btn_dir = 4'b0001;
        repeat (5) @(negedge clk);
        btn_dir = 4'd0;
        check_output("t5_over_ignores_btn", turns - t0, 0);
        check_output("t5_win_sticky", win, 1);
        check_output("t5_queue_drained", exp_q.size(), 0);

        // 5b) spawn fills the last hole of a locked board: lose
        apply_reset();
        b = '0; b[0] = 12'd8;
        load_board(b);
        m = checker_board(); m[5] = 12'd0;
        moved_board = m;
        push_exp(0, 0, 0, 0);
        push_exp(1, 5, 2, 6);
        apply_stimulus(4'b0001);
        wait_idle(40);
        check_output("t5_lose", lose, 1);
        check_output("t5_lose_no_win", win, 0);
        check_output("t5b_queue_drained", exp_q.size(), 0);

        // 5c) full board after move: full scan lap, no spawn, lose
        apply_reset();
        b = '0; b[0] = 12'd8;
        load_board(b);
        moved_board = checker_board();
        push_exp(0, 0, 0, 0);
        apply_stimulus(4'b0100);
        wait_idle(40);
        check_output("t5c_lose_full_scan", lose, 1);
        check_output("t5c_queue_drained", exp_q.size(), 0);

        // 6a) movement never ready: timeout pulse on the 64th MOVE cycle
        apply_reset();
        b = '0; b[0] = 12'd2;
        load_board(b);
        m = '0; m[3] = 12'd2;
        moved_board = m;
        ready_delay = -1;
        push_exp(2, 0, 0, 64);
        apply_stimulus(4'b0001);
        wait_idle(100);
        check_output("t6_queue_drained", exp_q.size(), 0);
        check_output("t6_board_unchanged", (board_in == b), 1);
        ready_delay = 1;

        // 6b) reset while scanning: no spawn strobe follows
        apply_reset();
        for (int i = 0; i < 15; i++) b[i] = (i % 2 == 0) ? 12'd2 : 12'd4;
        b[15] = 12'd0;
        load_board(b);
        m = b; m[14] = 12'd8;
        moved_board = m;
        push_exp(0, 0, 0, 0);
        apply_stimulus(4'b0001);
        n = 0;
        while (!board_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("t6_commit_seen", board_we, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_output("t6_idle_after_reset", busy, 0);
        check_output("t6b_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
